// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states, header width, byte flip.
package imem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HDR_HI = 3'd1,
      ST_HDR_LO = 3'd2,
      ST_LOAD   = 3'd3,
      ST_CHECK  = 3'd4,
      ST_DONE   = 3'd5,
      ST_ERROR  = 3'd6
   } state_t;

   localparam int unsigned HDR_WIDTH = 16;

   // Mirror of the ROM read-side flip: storing flipped words restores instruction order on read.
   function automatic logic [31:0] byte_flip(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if;

   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;

   modport master (
      output rx_data, rx_valid,
      input  rx_ready, wr_en, wr_addr, wr_data
   );

   modport slave (
      input  rx_data, rx_valid,
      output rx_ready, wr_en, wr_addr, wr_data
   );

endinterface

// File: rtl/imem_word_packer.sv
// Collects four stream bytes (instruction MSB first) and emits one byte-flipped word with a one-cycle valid.
module imem_word_packer
   import imem_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_valid
);

   logic [1:0]  byte_cnt;
   logic [23:0] shift;

   always_ff @(posedge clock) begin
      if (reset) begin
         byte_cnt   <= '0;
         shift      <= '0;
         word       <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         if (clear) begin
            byte_cnt <= '0;
            shift    <= '0;
         end else if (byte_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
               word       <= byte_flip({shift, byte_in});
               word_valid <= 1'b1;
            end else begin
               shift <= {shift[15:0], byte_in};
            end
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: 16-bit word-count header, then payload words written to instruction RAM.
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
   import imem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   imem_loader_if.slave  bus,
   output logic          cpu_hold,
   output logic          done,
   output logic          error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t ST_FINISH = ST_CHECK;
   logic [7:0] checksum;
`else
   localparam state_t ST_FINISH = ST_DONE;
`endif

   state_t                state;
   state_t                state_nx;
   logic [HDR_WIDTH-1:0]  count;
   logic [ADDR_WIDTH:0]   word_index;
   logic [31:0]           last_addr;
   logic [31:0]           word;
   logic                  word_valid;
   logic                  xfer;
   logic                  load_xfer;
   logic                  start_accept;
   logic                  last_write;
   logic [HDR_WIDTH-1:0]  hdr_count;
   logic                  hdr_zero;
   logic                  hdr_too_big;

   assign xfer         = bus.rx_valid && bus.rx_ready;
   assign load_xfer    = xfer && (state == ST_LOAD);
   assign start_accept = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
   assign last_write   = word_valid && (32'(word_index) == 32'(count) - 32'd1);
   assign hdr_count    = {count[15:8], bus.rx_data};
   assign hdr_zero     = (hdr_count == '0);
   assign hdr_too_big  = 32'(hdr_count) > (32'd1 << ADDR_WIDTH);

   imem_word_packer u_packer (
      .clock      (clock),
      .reset      (reset),
      .clear      (start_accept),
      .byte_valid (load_xfer),
      .byte_in    (bus.rx_data),
      .word       (word),
      .word_valid (word_valid)
   );

   // Address is live during the strobe and then held, since word_index moves on in the same cycle.
   assign bus.wr_en   = word_valid;
   assign bus.wr_data = word;
   assign bus.wr_addr = word_valid ? (32'(word_index) << 2) : last_addr;

   assign cpu_hold = (state != ST_DONE);
   assign done     = (state == ST_DONE);
   assign error    = (state == ST_ERROR);

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ST_IDLE;
         count      <= '0;
         word_index <= '0;
         last_addr  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         checksum   <= '0;
`endif
      end else begin
         state <= state_nx;
         if (start_accept) begin
            count      <= '0;
            word_index <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum   <= '0;
`endif
         end else begin
            if (xfer && state == ST_HDR_HI) count[15:8] <= bus.rx_data;
            if (xfer && state == ST_HDR_LO) count[7:0]  <= bus.rx_data;
            if (word_valid) begin
               word_index <= word_index + 1'b1;
               last_addr  <= 32'(word_index) << 2;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (load_xfer) checksum <= checksum ^ bus.rx_data;
`endif
         end
      end
   end

   always_comb begin
      state_nx     = state;
      bus.rx_ready = 1'b0;
      case (state)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) state_nx = ST_HDR_HI;
         end
         ST_HDR_HI: begin
            bus.rx_ready = 1'b1;
            if (xfer) state_nx = ST_HDR_LO;
         end
         ST_HDR_LO: begin
            bus.rx_ready = 1'b1;
            if (xfer) begin
               if (hdr_zero)         state_nx = ST_FINISH;
               else if (hdr_too_big) state_nx = ST_ERROR;
               else                  state_nx = ST_LOAD;
            end
         end
         ST_LOAD: begin
            // Stall during the final strobe so a trailing byte is never swallowed as payload.
            bus.rx_ready = !last_write;
            if (last_write) state_nx = ST_FINISH;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CHECK: begin
            bus.rx_ready = 1'b1;
            if (xfer) state_nx = (bus.rx_data == checksum) ? ST_DONE : ST_ERROR;
         end
`endif
         default: state_nx = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a stream-level model of the expected memory writes.
module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic cpu_hold, done, error;

   imem_loader_if bus ();

   imem_loader #(.ADDR_WIDTH(8)) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .bus      (bus),
      .cpu_hold (cpu_hold),
      .done     (done),
      .error    (error)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      bit          last;
   } wr_t;

   wr_t         exp_q[$];
   wr_t         w;
   int          checks = 0;
   int          failures = 0;
   bit          done_pend = 1'b0;
   logic [31:0] last_addr_seen = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Word as memory must hold it: first stream byte lands in the least significant byte.
   function automatic logic [31:0] model_word(input logic [7:0] b0, input logic [7:0] b1,
                                              input logic [7:0] b2, input logic [7:0] b3);
      return 32'(b0) + (32'(b1) << 8) + (32'(b2) << 16) + (32'(b3) << 24);
   endfunction

   always @(negedge clock) begin
      if (!reset) begin
         if (done_pend) begin
            check("done_after_last_wr", done, 1);
            check("hold_after_last_wr", cpu_hold, 0);
            done_pend = 1'b0;
         end
         if (bus.wr_en !== 1'b0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_wr_en", bus.wr_en, 0);
            end else begin
               w = exp_q.pop_front();
               check("wr_addr", bus.wr_addr, w.addr);
               check("wr_data", bus.wr_data, w.data);
               last_addr_seen = bus.wr_addr;
               if (w.last && !CSUM) done_pend = 1'b1;
            end
         end
      end else begin
         done_pend = 1'b0;
      end
   end

   task automatic send_byte(input logic [7:0] b, input int unsigned gap);
      int unsigned n;
      repeat (gap) begin
         @(negedge clock);
         bus.rx_valid = 1'b0;
         bus.rx_data  = 8'($urandom);
      end
      @(negedge clock);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      n = 0;
      while (bus.rx_ready !== 1'b1 && n < 40) begin
         @(negedge clock);
         n++;
      end
      if (bus.rx_ready !== 1'b1) check("rx_ready_timeout", bus.rx_ready, 1);
   endtask

   task automatic do_start();
      @(negedge clock);
      bus.rx_valid = 1'b0;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic load_image(input logic [15:0] cnt, input logic [7:0] pay[$],
                             input int unsigned gaps[$], input int unsigned maxgap,
                             input bit corrupt, input bit auto_exp);
      logic [7:0]  sum;
      bit          ok;
      int unsigned n;
      sum = 8'h00;
      ok  = (cnt <= 16'd256) && !(CSUM && corrupt);
      if (auto_exp && cnt <= 16'd256) begin
         for (int unsigned i = 0; i < 32'(cnt); i++)
            exp_q.push_back('{addr: 32'(i * 4),
                              data: model_word(pay[4*i], pay[4*i+1], pay[4*i+2], pay[4*i+3]),
                              last: (i == 32'(cnt) - 1)});
      end
      do_start();
      send_byte(cnt[15:8], 0);
      send_byte(cnt[7:0], 0);
      if (cnt > 16'd256) begin
         @(negedge clock);
         bus.rx_valid = 1'b0;
         check("oversize_error", error, 1);
         check("oversize_hold", cpu_hold, 1);
         check("oversize_rx_ready", bus.rx_ready, 0);
         check("oversize_done", done, 0);
         return;
      end
      for (int unsigned i = 0; i < pay.size(); i++) begin
         send_byte(pay[i], (i < gaps.size()) ? gaps[i] : $urandom_range(0, maxgap));
         sum ^= pay[i];
      end
      if (CSUM) send_byte(sum ^ (corrupt ? 8'h01 : 8'h00), $urandom_range(0, maxgap));
      @(negedge clock);
      bus.rx_valid = 1'b0;
      if (cnt == 16'd0) check("done_zero_count", done, 1);
      n = 0;
      while ((exp_q.size() != 0 || !(done || error)) && n < 20) begin
         @(negedge clock);
         n++;
      end
      check("writes_pending", 32'(exp_q.size()), 0);
      check("final_done", done, ok);
      check("final_error", error, !ok);
      check("final_hold", cpu_hold, !ok);
      check("final_rx_ready", bus.rx_ready, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rx_ready"}, bus.rx_ready, 0);
      check({tag, "_wr_en"}, bus.wr_en, 0);
      check({tag, "_wr_addr"}, bus.wr_addr, 0);
      check({tag, "_wr_data"}, bus.wr_data, 0);
      check({tag, "_hold"}, cpu_hold, 1);
      check({tag, "_done"}, done, 0);
      check({tag, "_error"}, error, 0);
   endtask

   initial begin
      #500000;
      failures++;
      $display("FAIL global_timeout actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0]  pay[$];
      int unsigned gaps[$];
      int unsigned nw;

      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      repeat (3) @(negedge clock);
      check_reset_outputs("reset");
      reset = 1'b0;
      @(negedge clock);

      // Two-word image with hand-computed memory contents
      exp_q.push_back('{addr: 32'h0, data: 32'h78563412, last: 1'b0});
      exp_q.push_back('{addr: 32'h4, data: 32'hF0DEBC9A, last: 1'b1});
      pay = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
      gaps = {};
      load_image(16'd2, pay, gaps, 0, 1'b0, 1'b0);

      pay = {};
      load_image(16'd0, pay, gaps, 0, 1'b0, 1'b0);

      load_image(16'h0101, pay, gaps, 0, 1'b0, 1'b0);
      load_image(16'h8000, pay, gaps, 0, 1'b0, 1'b0);

      // Single word with long valid gaps between early bytes
      exp_q.push_back('{addr: 32'h0, data: 32'h44332211, last: 1'b1});
      pay  = '{8'h11, 8'h22, 8'h33, 8'h44};
      gaps = '{0, 5, 5, 0};
      load_image(16'd1, pay, gaps, 0, 1'b0, 1'b0);
      gaps = {};

      // Abort mid-load: second word must never be written
      pay = {};
      for (int i = 0; i < 8; i++) pay.push_back(8'($urandom));
      exp_q.push_back('{addr: 32'h0, data: model_word(pay[0], pay[1], pay[2], pay[3]), last: 1'b0});
      do_start();
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      for (int i = 0; i < 6; i++) send_byte(pay[i], 0);
      @(negedge clock);
      bus.rx_valid = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      check_reset_outputs("midload_reset");
      check("midload_first_written", 32'(exp_q.size()), 0);
      exp_q.delete();
      reset = 1'b0;
      repeat (10) @(negedge clock);
      check("post_reset_idle_hold", cpu_hold, 1);

      // Full memory: count == depth
      pay = {};
      for (int i = 0; i < 1024; i++) pay.push_back(8'($urandom));
      load_image(16'd256, pay, gaps, 0, 1'b0, 1'b1);
      check("full_last_addr", last_addr_seen, 32'h3FC);

      for (int t = 0; t < 8; t++) begin
         nw  = $urandom_range(1, 8);
         pay = {};
         for (int unsigned i = 0; i < 4 * nw; i++) pay.push_back(8'($urandom));
         load_image(16'(nw), pay, gaps, 3, 1'($urandom_range(0, 1)), 1'b1);
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      pay = '{8'h01, 8'h02, 8'h04, 8'h08};
      load_image(16'd1, pay, gaps, 0, 1'b0, 1'b1);
      check("csum_good_done", done, 1);
      load_image(16'd1, pay, gaps, 0, 1'b1, 1'b1);
      check("csum_bad_error", error, 1);
`endif

      repeat (3) @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the instruction ROM: receives a program as a byte stream and writes 32-bit words into instruction RAM at sequential word addresses.
- Sits between the boot byte source (UART/debug link) and the instruction memory write port.
- Holds the core in reset (cpu_hold) until the image is complete.
- Stores words byte-flipped so the memory's read-side byte flip returns each instruction in original order.

Parameters:
ADDR_WIDTH, 8, log2 of instruction memory depth in words (depth = 2**ADDR_WIDTH).

Ports:
clock      input   1   system clock, all logic on rising edge
reset      input   1   reset, synchronous, active-high
start      input   1   one-cycle pulse; begins a load from IDLE/DONE/ERROR
rx_data    input   8   stream byte
rx_valid   input   1   rx_data valid
rx_ready   output  1   loader accepts byte this cycle (transfer = rx_valid & rx_ready)
wr_en      output  1   one-cycle memory write strobe
wr_addr    output  32  byte address of write (word_index << 2, bits [1:0] = 0)
wr_data    output  32  word to store, byte-flipped
cpu_hold   output  1   high while loading; core reset request
done       output  1   level; image loaded successfully
error      output  1   level; load aborted

Behaviour:
- Reset (synchronous): state IDLE, rx_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, error=0. All counters clear.
- FSM states: IDLE, HDR_HI, HDR_LO, LOAD, CHECK (CHECKSUM_EN only), DONE, ERROR.
- IDLE/DONE/ERROR:
  - rx_ready=0.
  - start → HDR_HI; clear done, error, word counter, byte counter, checksum; cpu_hold=1.
  - start is ignored in all other states.
- HDR_HI:
  - rx_ready=1.
  - On transfer, latch count[15:8] → HDR_LO.
- HDR_LO:
  - rx_ready=1.
  - On transfer, latch count[7:0].
  - count==0 → DONE.
  - count > 2**ADDR_WIDTH → ERROR.
  - Otherwise → LOAD.
- LOAD:
  - rx_ready=1.
  - Bytes arrive instruction-MSB first: b0 = instr[31:24] … b3 = instr[7:0].
  - Stored word: wr_data = {b3,b2,b1,b0}.
  - On the 4th byte transfer of a word, the next cycle has wr_en=1 with wr_addr = word_index*4; word_index increments in that same cycle.
  - wr_en is high exactly 1 cycle per word; wr_addr/wr_data hold their values until the next write.
  - After word count-1 is written: → CHECK if CHECKSUM_EN, else → DONE.
  - rx_valid gaps of any length are allowed; the byte counter (2 bits) wraps 3→0.
- DONE: done=1, cpu_hold=0. Entered on the cycle after the final wr_en.
- ERROR: error=1, cpu_hold=1, no further writes.
- Reset mid-load: abort immediately; no wr_en on the following cycle; partial words are discarded.
- Latency:
  - Last payload byte → final wr_en: 1 cycle.
  - Final wr_en → done: 1 cycle (non-checksum build).
- Width rules:
  - count is a 16-bit unsigned value.
  - word_index is ADDR_WIDTH+1 bits, so count == 2**ADDR_WIDTH is legal and fills memory exactly.
  - Upper wr_addr bits are zero.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - Running XOR of all payload bytes (header excluded).
  - After the last word, CHECK accepts one trailing byte (rx_ready=1).
  - Match → DONE; mismatch → ERROR. Words already written stay in memory.
  - count==0 also passes through CHECK, with expected checksum 8'h00.
- Undefined: no CHECK state; no trailing byte is consumed.

Decomposition:
- Shared package imem_pkg:
  - FSM state encoding constants.
  - Header width (16).
  - Byte-flip function, shared in spirit with the ROM's read flip.
- One natural sub-module: imem_word_packer (byte counter + 4-byte shift/assemble; emits word + word_valid pulse). The FSM lives in imem_loader.

Test Plan:
1. start; header 00 02; bytes 12 34 56 78 9A BC DE F0 → wr_en@addr 0 data 32'h78563412, wr_en@addr 4 data 32'hF0DEBC9A; done=1, cpu_hold=0 one cycle after the second write.
2. start; header 00 00 → no wr_en; done=1 one cycle after header low byte (checksum build: after trailing 00).
3. start; header 01 01 (257 > 256) → error=1, cpu_hold=1, rx_ready=0, no writes.
4. Header 00 01; bytes 11 22 with 5-cycle rx_valid gaps, then 33 44 → single wr_en, data 32'h44332211, addr 0.
5. Reset asserted after 6 payload bytes of a 2-word load → next cycle all outputs at reset values; no second wr_en; a new start loads cleanly.
6. (CHECKSUM_EN) header 00 01; bytes 01 02 04 08; trailer 0F → done=1; repeat with trailer 0E → error=1.
